bsg_dmc_ui_arbiter: RTL and testbench
=====================================

# bsg_dmc_ui_arbiter

Multi-port front end for the DMC user interface. It arbitrates `num_ports_p` independent client ports onto the single Xilinx-style `app_*` command/write/read interface of `bsg_dmc`. It serialises whole bursts (write data, then command) and routes in-order read returns back to the issuing port through a tag FIFO. It sits in the `ui_clk_i` domain, between client caches/DMA engines and the controller.

## Interface
- `num_ports_p`, default 4: number of client ports, ≥2.
- `ui_addr_width_p`, default 28: address width.
- `ui_data_width_p`, default 64: UI data width. Mask width is `ui_data_width_p/8`.
- `burst_len_p`, default 2: UI beats per transaction (`burst_data_width/ui_data_width`), ≥1.
- `rd_tag_depth_p`, default 8: maximum outstanding reads, power of 2.
- `ui_clk_i`, in, 1: the single clock.
- `ui_rst_n_i`, in, 1: reset, asynchronous, active-low. One clock and one reset only; polarity and synchronicity are fixed.
- `port_cmd_v_i`, in, N: per-port command valid.
- `port_cmd_write_i`, in, N: 1 = write, 0 = read.
- `port_addr_i`, in, N×addr: per-port address.
- `port_cmd_ready_o`, out, N: command consumed.
- `port_wdata_v_i`, in, N: write beat valid.
- `port_wdata_i`, in, N×data: write beat data.
- `port_wmask_i`, in, N×mask: write beat mask.
- `port_wdata_ready_o`, out, N: write beat consumed.
- `port_rdata_v_o`, out, N: read beat valid. No backpressure.
- `port_rdata_o`, out, data: read data, broadcast to all ports.
- `port_rdata_last_o`, out, 1: last beat of a burst.
- `app_addr_o`, out, addr: command address to the DMC.
- `app_cmd_o`, out, 3: command to the DMC.
- `app_en_o`, out, 1: command enable.
- `app_rdy_i`, in, 1: DMC command ready.
- `app_wdf_wren_o`, out, 1: write data enable.
- `app_wdf_data_o`, out, data: write data.
- `app_wdf_mask_o`, out, mask: write mask.
- `app_wdf_end_o`, out, 1: last write beat.
- `app_wdf_rdy_i`, in, 1: DMC write data ready.
- `app_rd_data_valid_i`, in, 1: DMC read data valid.
- `app_rd_data_i`, in, data: DMC read data.
- `app_rd_data_end_i`, in, 1: DMC last read beat.
- `rd_err_o`, out, 1: sticky; set when read data arrives while the tag FIFO is empty.

## Operation
- FSM states: IDLE, WDATA, CMD. Registers: grant index `g`, round-robin pointer `rr`, beat counter, tag FIFO, tag count.
- **IDLE:**
  - Eligible ports: `cmd_v & (write | tag_count < rd_tag_depth_p)`.
  - Winner is the first eligible port at or after `rr`; it is latched into `g` at the clock edge.
  - A write winner moves to WDATA; a read winner moves to CMD. No eligible port: stay in IDLE.
- **WDATA:**
  - `app_wdf_wren_o = port_wdata_v_i[g]`.
  - `port_wdata_ready_o[g] = app_wdf_rdy_i`.
  - Data and mask pass through from port `g`.
  - `app_wdf_end_o = (beat == burst_len_p-1)`.
  - A beat transfers when wren & rdy; beat increments. After the last beat transfers, the counter clears and the FSM moves to CMD.
- **CMD:**
  - `app_en_o = 1`; `app_addr_o = port_addr_i[g]`.
  - `app_cmd_o = 3'b000` for write, `3'b001` for read.
  - `port_cmd_ready_o[g] = app_rdy_i`.
  - On `app_rdy_i`: return to IDLE and set `rr = g+1` (mod N). For a read, also push `g` into the tag FIFO.
- **Port hold rule:** ports hold cmd, addr and write fields stable from `cmd_v` until `cmd_ready`.
- **Read return:** combinational.
  - `port_rdata_v_o[head] = app_rd_data_valid_i`; all other ports get 0.
  - `port_rdata_last_o = app_rd_data_end_i`.
  - Pop on `valid & end`.
  - Valid with an empty FIFO: no port valid, and `rd_err_o` is set.
- **Simultaneous push and pop:** count is unchanged and the FIFO pointers both advance.
- **Full-FIFO eligibility:** uses the registered count only. A same-cycle pop does not make a read eligible.
- All non-granted ports see `cmd_ready`/`wdata_ready` = 0.

## Timing
- Reset (async assert, sync to the next edge on release): FSM = IDLE, `rr = 0`, `g = 0`, beat = 0, FIFO empty, `rd_err_o = 0`. All outputs are 0, including `app_en_o`, `app_wdf_wren_o` and every ready/valid.
- Reset asserted mid-burst abandons the transaction. The DMC is reset in the same reset tree.
- Minimum write latency, with `app_*_rdy` always high: IDLE 1 cycle, then `burst_len_p` beat cycles, then 1 CMD cycle. Total `burst_len_p + 2` cycles per write.
- Minimum read latency: 2 cycles per read (IDLE, CMD).
- Read data to port: 0 cycles.
- Arbitration decision: 1 cycle, registered.
- `rr` wraps from N-1 to 0.
- Read ordering follows DMC return order, which is in issue order.

## Configuration
- `BSG_DMC_UI_ARB_FIXED_PRIO_EN` defined: fixed priority; the lowest-index eligible port always wins and `rr` is unused (held at 0).
- Not defined: round-robin as described in Operation.

## Test plan
- Four ports (N=4), all issue reads each cycle, `rr` starts at 0, `app_rdy_i = 1` -> grants go 0,1,2,3,0; each port gets exactly 1 of every 4 commands.
- Port 2 writes addr 0x100 with beats 0xA, 0xB (`burst_len_p = 2`), `app_wdf_rdy_i` low for 3 cycles -> `app_wdf_wren_o` beats 0xA then 0xB with `end` on 0xB. Then `app_en_o` with `app_cmd_o = 0`, addr 0x100. `port_cmd_ready_o[2]` pulses once.
- Reads from ports 1, 3, 1 issued, then 6 return beats -> `port_rdata_v_o` goes to 1,1,3,3,1,1 with `last` on beats 2, 4 and 6.
- With `rd_tag_depth_p = 8`, 8 reads outstanding -> a 9th read is not granted and a pending write still proceeds. After one return burst, the 9th read is granted.
- `app_rd_data_valid_i` pulses with the FIFO empty -> no port valid, `rd_err_o = 1` until reset.
- Reset asserted during WDATA beat 1 -> all outputs 0 immediately; after release, FSM is IDLE, `rr = 0` and the FIFO is empty. With `BSG_DMC_UI_ARB_FIXED_PRIO_EN` defined, ports 0 and 3 requesting continuously -> port 0 always granted.

Source files
------------

// File: rtl/bsg_dmc_ui_arbiter_if.sv
// bsg_dmc_ui_arbiter_if: app_* command/write/read bundle to bsg_dmc.
// master = arbiter side, slave = controller side.
interface bsg_dmc_ui_arbiter_if #(
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 64
);
  logic [ui_addr_width_p-1:0]   app_addr;
  logic [2:0]                   app_cmd;
  logic                         app_en;
  logic                         app_rdy;
  logic                         app_wdf_wren;
  logic [ui_data_width_p-1:0]   app_wdf_data;
  logic [ui_data_width_p/8-1:0] app_wdf_mask;
  logic                         app_wdf_end;
  logic                         app_wdf_rdy;
  logic                         app_rd_data_valid;
  logic [ui_data_width_p-1:0]   app_rd_data;
  logic                         app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en,
    input  app_rdy,
    output app_wdf_wren, app_wdf_data,
    output app_wdf_mask, app_wdf_end,
    input  app_wdf_rdy,
    input  app_rd_data_valid, app_rd_data,
    input  app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en,
    output app_rdy,
    input  app_wdf_wren, app_wdf_data,
    input  app_wdf_mask, app_wdf_end,
    output app_wdf_rdy,
    output app_rd_data_valid, app_rd_data,
    output app_rd_data_end
  );
endinterface

// File: rtl/bsg_dmc_ui_arbiter.sv
// bsg_dmc_ui_arbiter: N client ports onto one bsg_dmc app_* interface.
// Define BSG_DMC_UI_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module bsg_dmc_ui_arbiter #(
  parameter int num_ports_p     = 4,
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 64,
  parameter int burst_len_p     = 2,
  parameter int rd_tag_depth_p  = 8
) (
  input  logic ui_clk_i,
  input  logic ui_rst_n_i,

  input  logic [num_ports_p-1:0]                 port_cmd_v_i,
  input  logic [num_ports_p-1:0]                 port_cmd_write_i,
  input  logic [num_ports_p*ui_addr_width_p-1:0] port_addr_i,
  output logic [num_ports_p-1:0]                 port_cmd_ready_o,

  input  logic [num_ports_p-1:0]                     port_wdata_v_i,
  input  logic [num_ports_p*ui_data_width_p-1:0]     port_wdata_i,
  input  logic [num_ports_p*(ui_data_width_p/8)-1:0] port_wmask_i,
  output logic [num_ports_p-1:0]                     port_wdata_ready_o,

  output logic [num_ports_p-1:0]     port_rdata_v_o,
  output logic [ui_data_width_p-1:0] port_rdata_o,
  output logic                       port_rdata_last_o,

  bsg_dmc_ui_arbiter_if.master app,

  output logic rd_err_o
);

  localparam int N  = num_ports_p;
  localparam int AW = ui_addr_width_p;
  localparam int DW = ui_data_width_p;
  localparam int MW = ui_data_width_p / 8;
  localparam int IW = $clog2(N);
  localparam int BW = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int TW = (rd_tag_depth_p > 1) ? $clog2(rd_tag_depth_p) : 1;
  localparam int CW = $clog2(rd_tag_depth_p + 1);

  typedef enum logic [1:0] {IDLE, WDATA, CMD} state_e;

  state_e        state_r, state_n;
  logic [IW-1:0] g_r, rr_r, arb_start;
  logic [IW-1:0] win, idx;
  logic          win_v;
  logic [BW-1:0] beat_r;
  logic [IW-1:0] tag_mem [rd_tag_depth_p];
  logic [TW-1:0] wptr_r, rptr_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  elig;
  logic          tag_room, rd_has;
  logic          g_wr, last_beat;
  logic          wfire, cfire, push, pop;

  assign tag_room  = cnt_r < CW'(rd_tag_depth_p);
  assign rd_has    = cnt_r != '0;
  assign elig      = port_cmd_v_i
                   & (port_cmd_write_i | {N{tag_room}});
  assign arb_start = rr_r;

  // first eligible port at or after the pointer, wrapping
  always_comb begin
    win_v = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(arb_start) + i) % N);
      if (!win_v && elig[idx]) begin
        win_v = 1'b1;
        win   = idx;
      end
    end
  end

  assign g_wr      = port_cmd_write_i[g_r];
  assign last_beat = beat_r == BW'(burst_len_p - 1);
  assign wfire     = (state_r == WDATA)
                   & port_wdata_v_i[g_r] & app.app_wdf_rdy;
  assign cfire     = (state_r == CMD) & app.app_rdy;
  assign push      = cfire & ~g_wr;
  assign pop       = app.app_rd_data_valid
                   & app.app_rd_data_end & rd_has;

  always_comb begin
    state_n            = state_r;
    port_cmd_ready_o   = '0;
    port_wdata_ready_o = '0;
    app.app_en         = 1'b0;
    app.app_addr       = '0;
    app.app_cmd        = 3'b000;
    app.app_wdf_wren   = 1'b0;
    app.app_wdf_data   = '0;
    app.app_wdf_mask   = '0;
    app.app_wdf_end    = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (win_v)
          state_n = port_cmd_write_i[win] ? WDATA : CMD;
      end
      WDATA: begin
        app.app_wdf_wren = port_wdata_v_i[g_r];
        app.app_wdf_data = port_wdata_i[g_r*DW +: DW];
        app.app_wdf_mask = port_wmask_i[g_r*MW +: MW];
        app.app_wdf_end  = last_beat;
        port_wdata_ready_o[g_r] = app.app_wdf_rdy;
        if (wfire && last_beat)
          state_n = CMD;
      end
      CMD: begin
        app.app_en   = 1'b1;
        app.app_addr = port_addr_i[g_r*AW +: AW];
        app.app_cmd  = g_wr ? 3'b000 : 3'b001;
        port_cmd_ready_o[g_r] = app.app_rdy;
        if (app.app_rdy)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
    if (!ui_rst_n_i) begin
      state_r  <= IDLE;
      g_r      <= '0;
      rr_r     <= '0;
      beat_r   <= '0;
      wptr_r   <= '0;
      rptr_r   <= '0;
      cnt_r    <= '0;
      rd_err_o <= 1'b0;
    end else begin
      state_r <= state_n;
      if (state_r == IDLE && win_v)
        g_r <= win;
      if (wfire)
        beat_r <= last_beat ? '0 : beat_r + 1'b1;
`ifdef BSG_DMC_UI_ARB_FIXED_PRIO_EN
      rr_r <= '0;
`else
      if (cfire)
        rr_r <= (g_r == IW'(N - 1)) ? '0 : g_r + 1'b1;
`endif
      if (push)
        wptr_r <= (wptr_r == TW'(rd_tag_depth_p - 1))
                ? '0 : wptr_r + 1'b1;
      if (pop)
        rptr_r <= (rptr_r == TW'(rd_tag_depth_p - 1))
                ? '0 : rptr_r + 1'b1;
      if (push && !pop)
        cnt_r <= cnt_r + 1'b1;
      else if (pop && !push)
        cnt_r <= cnt_r - 1'b1;
      if (app.app_rd_data_valid && !rd_has)
        rd_err_o <= 1'b1;
    end
  end

  always_ff @(posedge ui_clk_i) begin
    if (push)
      tag_mem[wptr_r] <= g_r;
  end

  // returns are in issue order, so the FIFO head owns the beat
  always_comb begin
    port_rdata_v_o = '0;
    if (app.app_rd_data_valid && rd_has)
      port_rdata_v_o[tag_mem[rptr_r]] = 1'b1;
  end

  assign port_rdata_o      = app.app_rd_data;
  assign port_rdata_last_o = app.app_rd_data_end;

endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
// tb_bsg_dmc_ui_arbiter: random clients + DMC against a transaction model.
// Honours BSG_DMC_UI_ARB_FIXED_PRIO_EN like the design.
module tb_bsg_dmc_ui_arbiter;
  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int B  = 2;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    cmd_v, cmd_wr, cmd_rdy;
  logic [N-1:0]    wd_v, wd_rdy, rd_v;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*MW-1:0] wmask;
  logic [DW-1:0]   rdata;
  logic            rlast, rd_err;

  bsg_dmc_ui_arbiter_if #(.ui_addr_width_p(AW),
    .ui_data_width_p(DW)) app ();

  bsg_dmc_ui_arbiter #(
    .num_ports_p(N), .ui_addr_width_p(AW),
    .ui_data_width_p(DW), .burst_len_p(B),
    .rd_tag_depth_p(D)
  ) dut (
    .ui_clk_i(clk), .ui_rst_n_i(rst_n),
    .port_cmd_v_i(cmd_v), .port_cmd_write_i(cmd_wr),
    .port_addr_i(addr), .port_cmd_ready_o(cmd_rdy),
    .port_wdata_v_i(wd_v), .port_wdata_i(wdata),
    .port_wmask_i(wmask), .port_wdata_ready_o(wd_rdy),
    .port_rdata_v_o(rd_v), .port_rdata_o(rdata),
    .port_rdata_last_o(rlast), .app(app.master),
    .rd_err_o(rd_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // reference model state
  int m_owner, m_beats, m_rr;
  bit m_wr, m_err;
  int m_tags[$];
  logic [N-1:0]  e_crdy, e_wrdy, e_rv;
  logic          e_en, e_wren, e_wend, set_err, do_pop, do_push;
  logic [AW-1:0] e_addr;
  logic [2:0]    e_cmd;
  logic [DW-1:0] e_wd;
  logic [MW-1:0] e_wm;
  int            start, win, pp, push_port;
  bit            room, found;

  // observation logs and DMC bookkeeping
  logic [N-1:0] acc_cmd;
  int log_port[$], log_cmd[$], log_addr[$];
  logic [DW-1:0] wlog_d[$];
  int wlog_e[$], rlog_p[$], rlog_l[$];
  int crdy2_cnt, rd_issued, rd_sent, rbeat;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_beats = 0; m_rr = 0;
      m_wr = 0; m_err = 0; m_tags.delete();
      acc_cmd = '0; rd_issued = 0;
    end else begin
      e_crdy = '0; e_wrdy = '0; e_rv = '0;
      e_en = 0; e_wren = 0; e_wend = 0;
      e_addr = '0; e_cmd = '0; e_wd = '0; e_wm = '0;
      set_err = 0; do_pop = 0; do_push = 0;
      found = 0; win = 0; push_port = 0;
      if (app.app_rd_data_valid) begin
        if (m_tags.size() == 0) set_err = 1;
        else begin
          e_rv[m_tags[0]] = 1'b1;
          do_pop = app.app_rd_data_end;
        end
      end
      if (m_owner < 0) begin
`ifdef BSG_DMC_UI_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_rr;
`endif
        room = m_tags.size() < D;
        for (int k = 0; k < N; k++) begin
          pp = (start + k) % N;
          if (!found && cmd_v[pp] && (cmd_wr[pp] || room)) begin
            found = 1; win = pp;
          end
        end
      end else if (m_wr && m_beats < B) begin
        e_wren = wd_v[m_owner];
        e_wd   = wdata[m_owner*DW +: DW];
        e_wm   = wmask[m_owner*MW +: MW];
        e_wend = (m_beats == B - 1);
        e_wrdy[m_owner] = app.app_wdf_rdy;
      end else begin
        e_en   = 1;
        e_addr = addr[m_owner*AW +: AW];
        e_cmd  = m_wr ? 3'd0 : 3'd1;
        e_crdy[m_owner] = app.app_rdy;
      end
      chk("cmd_ready", cmd_rdy, e_crdy);
      chk("wdata_ready", wd_rdy, e_wrdy);
      chk("rdata_v", rd_v, e_rv);
      chk("app_en", app.app_en, e_en);
      chk("app_addr", app.app_addr, e_addr);
      chk("app_cmd", app.app_cmd, e_cmd);
      chk("wdf_wren", app.app_wdf_wren, e_wren);
      chk("wdf_data", app.app_wdf_data, e_wd);
      chk("wdf_mask", app.app_wdf_mask, e_wm);
      chk("wdf_end", app.app_wdf_end, e_wend);
      chk("rdata", rdata, app.app_rd_data);
      chk("rdata_last", rlast, app.app_rd_data_end);
      chk("rd_err", rd_err, m_err);
      // advance model across the coming edge
      m_err = m_err | set_err;
      if (found) begin
        m_owner = win; m_wr = cmd_wr[win]; m_beats = 0;
      end else if (m_owner >= 0 && m_wr && m_beats < B) begin
        if (wd_v[m_owner] && app.app_wdf_rdy) m_beats++;
      end else if (m_owner >= 0 && app.app_rdy) begin
        do_push = !m_wr; push_port = m_owner;
`ifndef BSG_DMC_UI_ARB_FIXED_PRIO_EN
        m_rr = (m_owner + 1) % N;
`endif
        m_owner = -1;
      end
      if (do_pop) void'(m_tags.pop_front());
      if (do_push) m_tags.push_back(push_port);
      // logs
      acc_cmd = cmd_v & cmd_rdy;
      if (cmd_rdy[2]) crdy2_cnt++;
      if (app.app_en && app.app_rdy) begin
        for (int k = 0; k < N; k++)
          if (cmd_rdy[k]) log_port.push_back(k);
        log_cmd.push_back(int'(app.app_cmd));
        log_addr.push_back(int'(app.app_addr));
        if (app.app_cmd == 3'd1) rd_issued++;
      end
      if (app.app_wdf_wren && app.app_wdf_rdy) begin
        wlog_d.push_back(app.app_wdf_data);
        wlog_e.push_back(int'(app.app_wdf_end));
      end
      for (int k = 0; k < N; k++)
        if (rd_v[k]) begin
          rlog_p.push_back(k); rlog_l.push_back(int'(rlast));
        end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic init_inputs();
    cmd_v = '0; cmd_wr = '0; addr = '0;
    wd_v = '0; wdata = '0; wmask = '0;
    app.app_rdy = 0; app.app_wdf_rdy = 0;
    app.app_rd_data_valid = 0; app.app_rd_data = '0;
    app.app_rd_data_end = 0;
  endtask

  task automatic clear_logs();
    log_port.delete(); log_cmd.delete(); log_addr.delete();
    wlog_d.delete(); wlog_e.delete();
    rlog_p.delete(); rlog_l.delete(); crdy2_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; init_inputs(); rbeat = 0; rd_sent = 0;
    tick(); rst_n = 1; tick();
  endtask

  task automatic issue(int p, bit wr, logic [AW-1:0] a);
    int budget = 40;
    cmd_v[p] = 1; cmd_wr[p] = wr; addr[p*AW +: AW] = a;
    wd_v[p] = wr; wdata[p*DW +: DW] = {$urandom, $urandom};
    wmask[p*MW +: MW] = MW'($urandom);
    app.app_rdy = 1; app.app_wdf_rdy = 1;
    do begin tick(); budget--; end
    while (!acc_cmd[p] && budget > 0);
    cmd_v[p] = 0; wd_v[p] = 0;
    chk($sformatf("issue_p%0d", p), acc_cmd[p], 1);
  endtask

  task automatic drain();
    int budget = 200;
    cmd_v = '0;
    while (rd_issued > rd_sent && budget > 0) begin
      app.app_rd_data_valid = 1;
      app.app_rd_data = {$urandom, $urandom};
      app.app_rd_data_end = (rbeat == B - 1);
      if (rbeat == B - 1) begin rbeat = 0; rd_sent++; end
      else rbeat++;
      tick(); budget--;
    end
    app.app_rd_data_valid = 0; app.app_rd_data_end = 0;
    chk("drain_left", rd_issued - rd_sent, 0);
  endtask

  task automatic rand_cycle(int seg, bit q);
    for (int p = 0; p < N; p++) begin
      if (acc_cmd[p]) cmd_v[p] = 0;
      if (!cmd_v[p] && !q && $urandom_range(3) == 0) begin
        cmd_v[p] = 1; cmd_wr[p] = 1'($urandom_range(1));
        addr[p*AW +: AW] = AW'($urandom);
      end
      wd_v[p] = $urandom_range(3) != 0;
      wdata[p*DW +: DW] = {$urandom, $urandom};
      wmask[p*MW +: MW] = MW'($urandom);
    end
    app.app_rdy = (seg == 1) ? 1'($urandom_range(1))
                             : ($urandom_range(3) != 0);
    app.app_wdf_rdy = $urandom_range(3) != 0;
    if ((rbeat > 0 || rd_issued > rd_sent) &&
        $urandom_range(seg == 1 ? 7 : 1) == 0) begin
      app.app_rd_data_valid = 1;
      app.app_rd_data = {$urandom, $urandom};
      app.app_rd_data_end = (rbeat == B - 1);
      if (rbeat == B - 1) begin rbeat = 0; rd_sent++; end
      else rbeat++;
    end else begin
      app.app_rd_data_valid = 0;
      app.app_rd_data_end = 1'($urandom_range(1));
    end
    tick();
  endtask

  int exp_p[6] = '{1, 1, 3, 3, 1, 1};
  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int cnt_a, cnt_b, budget;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    init_inputs(); rbeat = 0; rd_sent = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_app_en", app.app_en, 0);
    chk("rst_wren", app.app_wdf_wren, 0);
    chk("rst_cmd_ready", cmd_rdy, 0);
    chk("rst_wdata_ready", wd_rdy, 0);
    chk("rst_rdata_v", rd_v, 0);
    chk("rst_rd_err", rd_err, 0);
    rst_n = 1; tick();

    // all ports read: round-robin 0,1,2,3,0
    clear_logs();
    cmd_wr = '0; addr = {N*AW{1'b1}}; cmd_v = '1;
    app.app_rdy = 1;
    repeat (10) tick();
    cmd_v = '0;
    chk("rr_count", log_port.size(), 5);
    if (log_port.size() == 5)
      for (int i = 0; i < 5; i++)
        chk($sformatf("rr_grant%0d", i), log_port[i], exp_rr[i]);
    drain();

    // port 2 write with stalled write-data ready
    clear_logs();
    cmd_v[2] = 1; cmd_wr[2] = 1; addr[2*AW +: AW] = 28'h100;
    wd_v[2] = 1; wdata[2*DW +: DW] = 64'hA;
    wmask[2*MW +: MW] = 8'hFF;
    app.app_wdf_rdy = 0; app.app_rdy = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      app.app_wdf_rdy = (c >= 3);
      wdata[2*DW +: DW] = (wlog_d.size() == 0) ? 64'hA : 64'hB;
      if (acc_cmd[2]) begin cmd_v[2] = 0; wd_v[2] = 0; end
    end
    chk("wr_beats", wlog_d.size(), 2);
    if (wlog_d.size() == 2) begin
      chk("wr_beat0", wlog_d[0], 64'hA);
      chk("wr_end0", wlog_e[0], 0);
      chk("wr_beat1", wlog_d[1], 64'hB);
      chk("wr_end1", wlog_e[1], 1);
    end
    chk("wr_cmds", log_port.size(), 1);
    if (log_port.size() == 1) begin
      chk("wr_port", log_port[0], 2);
      chk("wr_cmd", log_cmd[0], 0);
      chk("wr_addr", log_addr[0], 28'h100);
    end
    chk("wr_ready_pulses", crdy2_cnt, 1);

    // read routing 1,3,1
    clear_logs();
    issue(1, 0, 28'h10); issue(3, 0, 28'h30); issue(1, 0, 28'h11);
    for (int i = 0; i < 6; i++) begin
      app.app_rd_data_valid = 1; app.app_rd_data = 64'(i);
      app.app_rd_data_end = (i % 2 == 1);
      if (i % 2 == 1) rd_sent++;
      tick();
    end
    app.app_rd_data_valid = 0; app.app_rd_data_end = 0;
    chk("route_beats", rlog_p.size(), 6);
    if (rlog_p.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("route_port%0d", i), rlog_p[i], exp_p[i]);
        chk($sformatf("route_last%0d", i), rlog_l[i], i % 2);
      end

    // full tag FIFO blocks reads but not writes
    clear_logs();
    for (int i = 0; i < D; i++) issue(i % N, 0, AW'(i));
    cmd_v[0] = 1; cmd_wr[0] = 0;
    cmd_v[1] = 1; cmd_wr[1] = 1; wd_v[1] = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (acc_cmd[1]) begin cmd_v[1] = 0; wd_v[1] = 0; end
    end
    cnt_a = 0; cnt_b = 0;
    for (int i = D; i < log_port.size(); i++) begin
      if (log_port[i] == 1 && log_cmd[i] == 0) cnt_a++;
      if (log_port[i] == 0) cnt_b++;
    end
    chk("full_write_granted", cnt_a, 1);
    chk("full_read_blocked", cnt_b, 0);
    for (int i = 0; i < B; i++) begin
      app.app_rd_data_valid = 1; app.app_rd_data_end = (i == B - 1);
      tick();
    end
    rd_sent++;
    app.app_rd_data_valid = 0; app.app_rd_data_end = 0;
    budget = 20;
    while (!acc_cmd[0] && budget > 0) begin tick(); budget--; end
    cmd_v[0] = 0;
    chk("full_read_after_pop", acc_cmd[0], 1);
    drain();

    // read data with empty FIFO
    app.app_rd_data_valid = 1; app.app_rd_data_end = 1;
    #1 chk("err_no_valid", rd_v, 0);
    tick();
    app.app_rd_data_valid = 0; app.app_rd_data_end = 0;
    chk("err_set", rd_err, 1);
    repeat (3) tick();
    chk("err_sticky", rd_err, 1);
    rst_n = 0;
    #1 chk("err_cleared", rd_err, 0);
    do_reset();

    // reset mid-burst; rr=3 and one read outstanding beforehand
    issue(2, 0, 28'h20);
    cmd_v[3] = 1; cmd_wr[3] = 1; wd_v[3] = 1;
    wdata[3*DW +: DW] = 64'h55; app.app_wdf_rdy = 1;
    tick(); tick();
    chk("mid_wren", app.app_wdf_wren, 1);
    chk("mid_end", app.app_wdf_end, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_app_en", app.app_en, 0);
    chk("mid_wren_rst", app.app_wdf_wren, 0);
    chk("mid_end_rst", app.app_wdf_end, 0);
    chk("mid_wdata_rst", app.app_wdf_data, 0);
    chk("mid_wdata_ready", wd_rdy, 0);
    chk("mid_cmd_ready", cmd_rdy, 0);
    init_inputs(); rbeat = 0; rd_sent = 0;
    tick(); rst_n = 1;
    app.app_rd_data_valid = 1; app.app_rd_data_end = 1;
    #1 chk("mid_fifo_empty_v", rd_v, 0);
    tick();
    app.app_rd_data_valid = 0; app.app_rd_data_end = 0;
    chk("mid_fifo_empty_err", rd_err, 1);
    clear_logs();
    cmd_v = '1; app.app_rdy = 1;
    tick(); tick();
    cmd_v = '0;
    chk("mid_first_grant_cnt", log_port.size(), 1);
    if (log_port.size() == 1) chk("mid_rr_zero", log_port[0], 0);
    do_reset();

`ifdef BSG_DMC_UI_ARB_FIXED_PRIO_EN
    clear_logs();
    cmd_v[0] = 1; cmd_v[3] = 1; app.app_rdy = 1;
    repeat (8) tick();
    cmd_v = '0;
    chk("fixed_cnt", log_port.size(), 4);
    foreach (log_port[i]) chk("fixed_port0", log_port[i], 0);
    do_reset();
`endif

    // randomized traffic checked by the model every cycle
    for (int seg = 0; seg < 3; seg++)
      for (int c = 0; c < 1500; c++) rand_cycle(seg, 0);
    budget = 600;
    while ((cmd_v != '0 || rd_issued != rd_sent || rbeat != 0)
           && budget > 0) begin
      rand_cycle(2, 1); budget--;
    end
    chk("quiesce_cmds", cmd_v, 0);
    chk("quiesce_reads", rd_issued - rd_sent, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
